skein_nonce_scanner: RTL and testbench

Nonce sequencer and result checker on the far side of the `skein512` pipelined hash core. It drives the core's `nonce` input through a programmed range, one nonce per two clocks to match the core's two-pass phase cadence. It samples `hash` back at the matching pipeline offset and compares the leading 64 bits against a target. Qualifying ("golden") nonces are queued in a small FIFO for the host/controller over a valid/ready handshake.

---
 rtl/skein_nonce_scanner.sv | 186 ++++++++++++++++++
 tb/tb_skein_nonce_scanner.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/skein_nonce_scanner.sv
// skein_nonce_scanner
//   Walks the skein512 core's nonce input through an inclusive range, one nonce
//   every two clocks, and samples the core's hash HASH_LATENCY clocks later. The
//   leading 64 hash bits are compared, unsigned, against a target. Nonces whose
//   hash is at or below the target are queued in a small result FIFO.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       begin a scan (accepted only when idle)
//   nonce_start/nonce_end       inclusive nonce range (wraps through 2^32)
//   target                      hit threshold for core_hash[511:448]
//   busy, done                  scan in progress / one-cycle completion pulse
//   core_nonce, core_hash       drive to / result from the hash core
//   result_valid/ready/nonce    FIFO head, valid/ready handshake
//   overflow                    sticky: a hit was dropped on a full FIFO
module skein_nonce_scanner #(
  parameter int HASH_LATENCY = 92,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [63:0]  target,
  output logic         busy,
  output logic         done,
  output logic [31:0]  core_nonce,
  input  logic [511:0] core_hash,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [31:0]  result_nonce,
  output logic         overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(HASH_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

  state_t        state_q;
  logic [31:0]   core_nonce_q;  // issue-side nonce
  logic [31:0]   iss_left_q;    // nonces still to issue after the current one
  logic          iss_ph_q;      // 0: first cycle of a nonce, 1: second
  logic [31:0]   chk_nonce_q;   // nonce belonging to the next hash sample
  logic [31:0]   chk_left_q;    // samples still to check after the next one
  logic          chk_ph_q;      // 0: sample cycle, 1: skip cycle
  logic [LW-1:0] lat_q;         // clocks until the first hash emerges
  logic [63:0]   tgt_q;
  logic          busy_q;
  logic          done_q;
  logic          ovf_q;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          rvalid_q;
  logic [31:0]   rnonce_q;

  logic          sample;
  logic          hit;
  logic          pop;
  logic          full;
  logic          push;
  logic          drop;
  logic [AW:0]   cnt_d;
  logic [AW-1:0] rd_ptr_d;
  logic [31:0]   head_d;

  // Only the leading 64 hash bits take part in the comparison.
  logic          unused_hash_lo;
  assign unused_hash_lo = ^core_hash[447:0];

  always_comb begin
    sample   = (state_q != S_IDLE) && (lat_q == '0) && !chk_ph_q;
    hit      = sample && (core_hash[511:448] <= tgt_q);
    pop      = rvalid_q && result_ready;
    full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
    // A pop frees the slot in the same cycle, so a full FIFO still takes the hit.
    push     = hit && (!full || pop);
    drop     = hit && full && !pop;
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    // If the new head is the slot being written this cycle, bypass the memory.
    head_d   = (push && (wr_ptr_q == rd_ptr_d)) ? chk_nonce_q : mem_q[rd_ptr_d];
  end

  // FIFO storage carries data only; emptiness is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= chk_nonce_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      core_nonce_q <= '0;
      iss_left_q   <= '0;
      iss_ph_q     <= 1'b0;
      chk_nonce_q  <= '0;
      chk_left_q   <= '0;
      chk_ph_q     <= 1'b0;
      lat_q        <= '0;
      tgt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      rvalid_q     <= 1'b0;
      rnonce_q     <= '0;
    end else begin
      done_q   <= 1'b0;

      // Result FIFO bookkeeping; the head is registered one cycle after a pop.
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rvalid_q <= (cnt_d != '0);
      if (cnt_d != '0) rnonce_q <= head_d;
      if (drop) ovf_q <= 1'b1;

      // Issue side
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_SCAN;
            core_nonce_q <= nonce_start;
            chk_nonce_q  <= nonce_start;
            iss_left_q   <= nonce_end - nonce_start;
            chk_left_q   <= nonce_end - nonce_start;
            iss_ph_q     <= 1'b0;
            chk_ph_q     <= 1'b0;
            lat_q        <= LW'(HASH_LATENCY);
            tgt_q        <= target;
            busy_q       <= 1'b1;
            ovf_q        <= 1'b0;
          end
        end
        S_SCAN: begin
          iss_ph_q <= ~iss_ph_q;
          if (iss_ph_q) begin
            if (iss_left_q == '0) begin
              // Last nonce issued; core_nonce keeps holding it.
              state_q <= S_DRAIN;
            end else begin
              core_nonce_q <= core_nonce_q + 32'd1;
              iss_left_q   <= iss_left_q - 32'd1;
            end
          end
        end
        default: ;
      endcase

      // Check side: runs in SCAN and DRAIN. The final sample always lands after
      // issue has finished (HASH_LATENCY >= 2), so returning to IDLE here never
      // competes with the SCAN->DRAIN transition.
      if (state_q != S_IDLE) begin
        if (lat_q != '0) begin
          lat_q <= lat_q - LW'(1);
        end else begin
          chk_ph_q <= ~chk_ph_q;
          if (!chk_ph_q) begin
            if (chk_left_q == '0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              chk_left_q  <= chk_left_q - 32'd1;
              chk_nonce_q <= chk_nonce_q + 32'd1;
            end
          end
        end
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign core_nonce   = core_nonce_q;
  assign result_valid = rvalid_q;
  assign result_nonce = rnonce_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_skein_nonce_scanner.sv
// Testbench for skein_nonce_scanner. A behavioural core model delays core_nonce
// by HASH_LATENCY clocks and returns hash[511:448] = {32'h0, nonce}. Expected
// FIFO entries are queued when a scan is launched and compared on every pop.
module tb_skein_nonce_scanner;

  localparam int L = 92;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic [63:0]  target;
  logic         busy;
  logic         done;
  logic [31:0]  core_nonce;
  logic [511:0] core_hash;
  logic         result_valid;
  logic         result_ready;
  logic [31:0]  result_nonce;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic        rv_at_done;
  logic [31:0] rn_at_done;
  logic        ovf_at_done;

  skein_nonce_scanner #(.HASH_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .nonce_start  (nonce_start),
    .nonce_end    (nonce_end),
    .target       (target),
    .busy         (busy),
    .done         (done),
    .core_nonce   (core_nonce),
    .core_hash    (core_hash),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_nonce (result_nonce),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Core model: dly[L-1] holds the nonce driven L cycles ago.
  logic [31:0] dly [L];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) dly[i] <= dly[i-1];
    dly[0] <= core_nonce;
  end
  assign core_hash = {32'h0, dly[L-1], {448{1'b1}}};

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every handshake pops one expected nonce.
  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      if (exp_q.size() == 0) check_eq("pop_extra", {63'd0, result_valid}, 64'd0);
      else check_eq("pop_nonce", {32'd0, result_nonce}, {32'd0, exp_q.pop_front()});
    end
  end

  // Launch a scan, check the issued nonce sequence and completion timing.
  // cap limits how many hits the FIFO can keep (consumer stalled);
  // ready_at raises result_ready on that scan cycle (-1: never).
  task automatic run_scan(input logic [31:0] s, input logic [31:0] e,
                          input logic [63:0] t, input int cap, input int ready_at);
    logic [31:0] n;
    logic [31:0] nn;
    int cyc;
    int pushed;
    bit seen;
    n = e - s;
    pushed = 0;
    for (int k = 0; k <= int'(n); k++) begin
      nn = s + k;
      if ({32'h0, nn} <= t && pushed < cap) begin
        exp_q.push_back(nn);
        pushed++;
      end
    end
    nonce_start = s;
    nonce_end   = e;
    target      = t;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    check_eq("busy_c0", {63'd0, busy}, 64'd1);
    check_eq("ovf_cleared", {63'd0, overflow}, 64'd0);
    cyc = 0;
    seen = 1'b0;
    while (cyc < L + 2 * int'(n) + 20) begin
      if (cyc <= 2 * int'(n) + 1) check_eq("core_nonce", {32'd0, core_nonce}, {32'd0, s + 32'(cyc / 2)});
      else check_eq("core_nonce_hold", {32'd0, core_nonce}, {32'd0, e});
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (cyc == ready_at) result_ready = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("done_seen", {63'd0, seen}, 64'd1);
    check_eq("done_cycle", 64'(cyc), 64'(L + 2 * int'(n) + 1));
    check_eq("busy_at_done", {63'd0, busy}, 64'd0);
    rv_at_done  = result_valid;
    rn_at_done  = result_nonce;
    ovf_at_done = overflow;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("drain_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    check_eq("empty_after_drain", {63'd0, result_valid}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    nonce_start  = '0;
    nonce_end    = '0;
    target       = '0;
    result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy",   {63'd0, busy}, 64'd0);
    check_eq("rst_done",   {63'd0, done}, 64'd0);
    check_eq("rst_nonce",  {32'd0, core_nonce}, 64'd0);
    check_eq("rst_valid",  {63'd0, result_valid}, 64'd0);
    check_eq("rst_rnonce", {32'd0, result_nonce}, 64'd0);
    check_eq("rst_ovf",    {63'd0, overflow}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single nonce, every hash hits.
    result_ready = 1'b1;
    run_scan(32'h10, 32'h10, {64{1'b1}}, 99, -1);
    check_eq("single_valid", {63'd0, rv_at_done}, 64'd1);
    check_eq("single_nonce", {32'd0, rn_at_done}, 64'h10);
    wait_drain();

    // Threshold: only nonces 0..3 qualify.
    run_scan(32'h0, 32'h7, 64'd3, 99, -1);
    wait_drain();

    // Wrap through 0xFFFFFFFF.
    run_scan(32'hFFFF_FFFE, 32'h1, {64{1'b1}}, 99, -1);
    wait_drain();

    // Overflow with a stalled consumer.
    result_ready = 1'b0;
    run_scan(32'h0, 32'h5, {64{1'b1}}, D - exp_q.size(), -1);
    check_eq("ovf_set", {63'd0, ovf_at_done}, 64'd1);
    check_eq("ovf_valid", {63'd0, rv_at_done}, 64'd1);
    check_eq("ovf_head", {32'd0, rn_at_done}, 64'd0);
    result_ready = 1'b1;
    wait_drain();
    check_eq("ovf_sticky", {63'd0, overflow}, 64'd1);

    // Fill the FIFO, then hit on a full FIFO while popping.
    result_ready = 1'b0;
    run_scan(32'h100, 32'h103, {64{1'b1}}, D - exp_q.size(), -1);
    check_eq("fill_no_ovf", {63'd0, ovf_at_done}, 64'd0);
    run_scan(32'h200, 32'h200, {64{1'b1}}, 99, L);
    check_eq("fullpp_no_ovf", {63'd0, ovf_at_done}, 64'd0);
    wait_drain();

    // Reset in the middle of a scan with two entries queued.
    result_ready = 1'b0;
    run_scan(32'h300, 32'h301, {64{1'b1}}, D - exp_q.size(), -1);
    nonce_start = 32'h400;
    nonce_end   = 32'h40F;
    target      = {64{1'b1}};
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy",   {63'd0, busy}, 64'd0);
    check_eq("mid_rst_done",   {63'd0, done}, 64'd0);
    check_eq("mid_rst_nonce",  {32'd0, core_nonce}, 64'd0);
    check_eq("mid_rst_valid",  {63'd0, result_valid}, 64'd0);
    check_eq("mid_rst_rnonce", {32'd0, result_nonce}, 64'd0);
    check_eq("mid_rst_ovf",    {63'd0, overflow}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b1;
    run_scan(32'h20, 32'h22, 64'h21, 99, -1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
